// File: rtl/sample_pack_writer.sv
// Packs a framed stream of narrow samples into FIFO-width words and writes them
// to an indirect CDC FIFO, tracking free space from the consumer's Gray read pointer.
module sample_pack_writer #(
    parameter int DSIZE = 32,
    parameter int SSIZE = 8,
    parameter int ASIZE = 3
) (
    input  logic               i_wr_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [15:0]        i_len,
    input  logic               i_sample_valid,
    input  logic [SSIZE-1:0]   i_sample,
    output logic               o_sample_ready,
    input  logic [ASIZE:0]     i_rd_ptr_gray,
    output logic               o_wr_req,
    output logic [DSIZE-1:0]   o_wr_data,
    output logic [ASIZE:0]     o_level,
    output logic               o_busy,
    output logic               o_done
);

    localparam int PACK  = DSIZE / SSIZE;
    localparam int DEPTH = 1 << ASIZE;
    localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {IDLE, FILL, PUSH, DONE} state_t;

    state_t                        state_q, state_n;
    logic [15:0]                   remaining_q, remaining_n;
    logic [LW-1:0]                 lane_q, lane_n;
    logic [PACK-1:0][SSIZE-1:0]    pack_q, pack_n;
    logic [ASIZE:0]                wptr_q, wptr_n;
    logic [ASIZE:0]                sync1_q, sync2_q;
    logic [ASIZE:0]                rptr, level;
    logic                          full, wr_req;

    // Read pointer crosses in Gray code, so a two-flop stage is enough.
    always_ff @(posedge i_wr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_rd_ptr_gray;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        for (int i = 0; i <= ASIZE; i++)
            rptr[i] = ^(sync2_q >> i);
    end

    // rptr lags the real read pointer, so level can only overstate occupancy.
    assign level = wptr_q - rptr;
    assign full  = (level == (ASIZE+1)'(DEPTH));

    always_ff @(posedge i_wr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            wptr_q      <= '0;
        end else begin
            state_q     <= state_n;
            remaining_q <= remaining_n;
            lane_q      <= lane_n;
            pack_q      <= pack_n;
            wptr_q      <= wptr_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        remaining_n = remaining_q;
        lane_n      = lane_q;
        pack_n      = pack_q;
        wptr_n      = wptr_q;
        wr_req      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    remaining_n = i_len;
                    lane_n      = '0;
                    pack_n      = '0;
                    state_n     = (i_len == 16'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (i_sample_valid) begin
                    pack_n[lane_q] = i_sample;
                    lane_n         = lane_q + 1'b1;
                    remaining_n    = remaining_q - 16'd1;
                    if (lane_q == LW'(PACK-1) || remaining_q == 16'd1)
                        state_n = PUSH;
                end
            end
            PUSH: begin
                // Stall here with the word held until a credit comes back.
                if (!full) begin
                    wr_req  = 1'b1;
                    wptr_n  = wptr_q + 1'b1;
                    pack_n  = '0;
                    lane_n  = '0;
                    state_n = (remaining_q != 16'd0) ? FILL : DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign o_sample_ready = (state_q == FILL);
    assign o_wr_req       = wr_req;
    assign o_wr_data      = pack_q;
    assign o_level        = level;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = (state_q == DONE);

endmodule

// File: tb/tb_sample_pack_writer.sv
// Scoreboard bench for sample_pack_writer: expected words queued at stimulus time,
// popped on every FIFO write strobe; consumer modelled by a Gray read pointer.
module tb_sample_pack_writer;

    logic        clk = 0, rst_n = 1, start = 0;
    logic [15:0] len_i = 0;
    logic        valid, ready, wr_req, busy, done;
    logic [7:0]  sample;
    logic [3:0]  rd_gray, level;
    logic [31:0] wr_data;

    sample_pack_writer #(.DSIZE(32), .SSIZE(8), .ASIZE(3)) dut (
        .i_wr_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len_i),
        .i_sample_valid(valid), .i_sample(sample), .o_sample_ready(ready),
        .i_rd_ptr_gray(rd_gray), .o_wr_req(wr_req), .o_wr_data(wr_data),
        .o_level(level), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Consumer model: either follows the write count or holds a fixed pointer.
    logic       follow = 1;
    logic [3:0] hold_gray = 0;
    logic [3:0] wr_cnt = 0;
    assign rd_gray = follow ? gray(wr_cnt) : hold_gray;

    logic [7:0]  s_q[$];
    logic [31:0] exp_q[$];
    int cyc = 0, wr_total = 0, done_cnt = 0, acc_cnt = 0;
    int last_wr_cyc = 0, prev_wr_cyc = 0, done_cyc = 0;
    logic [3:0] done_level = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) wr_cnt = 0;
        else begin
            if (wr_req) begin
                chk("wr_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("wr_data", wr_data, exp_q.pop_front());
                wr_total++;
                wr_cnt++;
                prev_wr_cyc = last_wr_cyc;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc   = cyc;
                done_level = level;
            end
        end
    end

    // Sample driver: presents the head of s_q, pops it when accepted.
    initial begin
        logic acc;
        valid = 0;
        sample = 0;
        forever begin
            @(negedge clk);
            acc = valid && ready && rst_n;
            @(posedge clk);
            #1;
            if (acc && s_q.size() > 0) begin
                void'(s_q.pop_front());
                acc_cnt++;
            end
            if (s_q.size() > 0) begin valid = 1; sample = s_q[0]; end
            else begin valid = 0; sample = 0; end
        end
    end

    task automatic push_frame(input int n, input logic [7:0] base);
        logic [31:0] w = '0;
        logic [7:0]  s;
        for (int i = 0; i < n; i++) begin
            s = base + 8'(i);
            s_q.push_back(s);
            w[(i % 4) * 8 +: 8] = s;
            if (i % 4 == 3 || i == n - 1) begin
                exp_q.push_back(w);
                w = '0;
            end
        end
    endtask

    task automatic start_frame(input logic [15:0] l);
        @(posedge clk); #1;
        start = 1;
        len_i = l;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt - d0), 1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        #1;
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_wr_req"}, 32'(wr_req), 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        s_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
    endtask

    initial begin
        int w0, c, n, a0;
        #3;
        do_reset("rst0");

        // 8 samples back to back, consumer keeps up
        w0 = wr_total;
        push_frame(8, 8'h01);
        start_frame(8);
        @(negedge clk);
        chk("t8_busy", 32'(busy), 1);
        chk("t8_ready", 32'(ready), 1);
        wait_done("t8_done", 100);
        chk("t8_writes", 32'(wr_total - w0), 2);
        chk("t8_spacing", 32'(last_wr_cyc - prev_wr_cyc), 5);
        chk("t8_done_lat", 32'(done_cyc - last_wr_cyc), 1);
        repeat (4) @(negedge clk);
        chk("t8_level", 32'(level), 0);

        // short final word padded with zeros
        w0 = wr_total;
        push_frame(5, 8'h11);
        start_frame(5);
        wait_done("t5_done", 100);
        chk("t5_writes", 32'(wr_total - w0), 2);

        // zero-length frame
        w0 = wr_total;
        start_frame(0);
        @(negedge clk);
        chk("t0_busy", 32'(busy), 1);
        chk("t0_done", 32'(done), 1);
        chk("t0_ready", 32'(ready), 0);
        @(negedge clk);
        chk("t0_busy_end", 32'(busy), 0);
        chk("t0_done_end", 32'(done), 0);
        chk("t0_writes", 32'(wr_total - w0), 0);

        // backpressure: read pointer held at 0
        @(negedge clk);
        do_reset("rst1");
        follow = 0;
        hold_gray = 0;
        w0 = wr_total;
        push_frame(40, 8'h40);
        start_frame(40);
        n = 0;
        while (wr_total - w0 < 8 && n < 200) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
        chk("bp_writes", 32'(wr_total - w0), 8);
        chk("bp_level", 32'(level), 8);
        chk("bp_wr_req", 32'(wr_req), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_data", wr_data, exp_q[0]);
        repeat (3) @(negedge clk);
        chk("bp_data_stable", wr_data, exp_q[0]);
        @(posedge clk); #1;
        c = cyc;
        hold_gray = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("bp_level_sync1", 32'(level), 8);
        @(negedge clk);
        chk("bp_level_drop", 32'(level), 7);
        chk("bp_wr_resume", 32'(wr_req), 1);
        @(negedge clk);
        chk("bp_writes9", 32'(wr_total - w0), 9);
        chk("bp_wr_lat", 32'(last_wr_cyc - c), 2);
        chk("bp_level_full", 32'(level), 8);
        follow = 1;
        wait_done("bp_done", 200);
        chk("bp_writes_all", 32'(wr_total - w0), 10);
        chk("bp_queue_empty", 32'(exp_q.size()), 0);

        // wrap: 8 more words take wptr from 10 past 16
        w0 = wr_total;
        push_frame(32, 8'h80);
        start_frame(32);
        wait_done("wrap_done", 200);
        chk("wrap_writes", 32'(wr_total - w0), 8);
        repeat (4) @(negedge clk);
        chk("wrap_level", 32'(level), 0);

        // reset mid-FILL with 3 lanes filled
        w0 = wr_total;
        a0 = acc_cnt;
        push_frame(8, 8'hC0);
        start_frame(8);
        n = 0;
        while (acc_cnt - a0 < 3 && n < 50) begin @(posedge clk); #2; n++; end
        chk("mid_accepts", 32'(acc_cnt - a0), 3);
        do_reset("rst2");
        repeat (10) @(negedge clk);
        chk("mid_no_write", 32'(wr_total - w0), 0);
        w0 = wr_total;
        push_frame(4, 8'hA1);
        start_frame(4);
        wait_done("mid_done", 100);
        chk("mid_writes", 32'(wr_total - w0), 1);
        chk("mid_level_at_done", 32'(done_level), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
